// File: rtl/req_grant_client.sv
// Requester side of the round-robin req/grant handshake: one burst engine per client,
// plus per-client starvation detection and a sticky protocol-violation flag.
module req_grant_client #(
    parameter int NUM_CLIENTS = 4,
    parameter int LEN_W       = 4,
    parameter int TIMEOUT     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CLIENTS-1:0]       cmd_valid,
    input  logic [NUM_CLIENTS*LEN_W-1:0] cmd_len,
    output logic [NUM_CLIENTS-1:0]       cmd_ready,
    output logic [NUM_CLIENTS-1:0]       req,
    input  logic [NUM_CLIENTS-1:0]       grant,
    output logic [NUM_CLIENTS-1:0]       beat,
    output logic [NUM_CLIENTS-1:0]       done,
    output logic [NUM_CLIENTS-1:0]       starve,
    output logic                         err
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, REL} state_e;

    state_e                 state_q  [NUM_CLIENTS];
    state_e                 state_d  [NUM_CLIENTS];
    logic [LEN_W-1:0]       len_q    [NUM_CLIENTS];
    logic [LEN_W-1:0]       len_d    [NUM_CLIENTS];
    logic [LEN_W-1:0]       cnt_q    [NUM_CLIENTS];
    logic [LEN_W-1:0]       cnt_d    [NUM_CLIENTS];
    logic [WAIT_W-1:0]      wait_q   [NUM_CLIENTS];
    logic [WAIT_W-1:0]      wait_d   [NUM_CLIENTS];
    logic [NUM_CLIENTS-1:0] starve_q;
    logic [NUM_CLIENTS-1:0] starve_d;
    logic                   err_q;
    logic                   err_d;
    logic                   multi_hot;

    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
        if (v >= WAIT_W'(TIMEOUT)) begin
            return WAIT_W'(TIMEOUT);
        end
        return v + WAIT_W'(1);
    endfunction

    // req/done/cmd_ready decode straight from registered state, so they are glitch-free
    for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_out
        assign req[g]       = (state_q[g] == REQ);
        assign cmd_ready[g] = (state_q[g] == IDLE);
        assign done[g]      = (state_q[g] == REL);
    end

    assign beat      = req & grant;
    assign starve    = starve_q;
    assign err       = err_q;
    assign multi_hot = |(grant & (grant - NUM_CLIENTS'(1)));

    always_comb begin
        err_d = err_q | (|(grant & ~req)) | multi_hot;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            state_d[i]  = state_q[i];
            len_d[i]    = len_q[i];
            cnt_d[i]    = cnt_q[i];
            wait_d[i]   = '0;
            starve_d[i] = 1'b0;
            case (state_q[i])
                IDLE: begin
                    if (cmd_valid[i]) begin
                        state_d[i] = REQ;
                        len_d[i]   = cmd_len[i*LEN_W +: LEN_W];
                        cnt_d[i]   = '0;
                    end
                end
                REQ: begin
                    if (beat[i]) begin
                        // completion on equality keeps cnt from ever wrapping
                        if (cnt_q[i] == len_q[i]) begin
                            state_d[i] = REL;
                        end else begin
                            cnt_d[i] = cnt_q[i] + LEN_W'(1);
                        end
                    end else begin
                        wait_d[i]   = sat_inc(wait_q[i]);
                        starve_d[i] = (wait_d[i] == WAIT_W'(TIMEOUT));
                    end
                end
                REL:     state_d[i] = IDLE;
                default: state_d[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
                wait_q[i]  <= '0;
            end
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                wait_q[i]  <= wait_d[i];
            end
            starve_q <= starve_d;
            err_q    <= err_d;
        end
    end

    // burst length is pure data and is only consumed after an accept
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            len_q[i] <= len_d[i];
        end
    end

endmodule

// File: tb/tb_req_grant_client.sv
// Directed and randomized bench for req_grant_client against a burst-level model
// (beats remaining, release pending, wait count) evaluated once per clock.
module tb_req_grant_client;

    localparam int N  = 4;
    localparam int LW = 4;
    localparam int T  = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    cmd_valid = '0;
    logic [N*LW-1:0] cmd_len = '0;
    logic [N-1:0]    cmd_ready;
    logic [N-1:0]    req;
    logic [N-1:0]    grant = '0;
    logic [N-1:0]    beat;
    logic [N-1:0]    done;
    logic [N-1:0]    starve;
    logic            err;

    req_grant_client #(.NUM_CLIENTS(N), .LEN_W(LW), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_len(cmd_len),
        .cmd_ready(cmd_ready), .req(req), .grant(grant), .beat(beat),
        .done(done), .starve(starve), .err(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // model: beats left in the current burst, release cycle pending, wait count
    int rem   [N];
    bit rel   [N];
    int waitc [N];
    bit stv   [N];
    bit err_m;
    int nb [N];
    int nd [N];
    int ptr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic clr_counts();
        for (int i = 0; i < N; i++) begin
            nb[i] = 0;
            nd[i] = 0;
        end
    endtask

    function automatic logic [N-1:0] req_model();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = (rem[i] > 0);
        return r;
    endfunction

    // one clock: inputs already driven after the falling edge
    task automatic cycle();
        logic [N-1:0] req_e, rdy_e, done_e, stv_e;
        for (int i = 0; i < N; i++) begin
            req_e[i]  = (rem[i] > 0);
            rdy_e[i]  = (rem[i] == 0) && !rel[i];
            done_e[i] = rel[i];
            stv_e[i]  = stv[i];
        end
        #1;
        if (chk_en) begin
            chk("req", 32'(req), 32'(req_e));
            chk("cmd_ready", 32'(cmd_ready), 32'(rdy_e));
            chk("done", 32'(done), 32'(done_e));
            chk("beat", 32'(beat), 32'(req_e & grant));
            chk("starve", 32'(starve), 32'(stv_e));
            chk("err", 32'(err), 32'(err_m));
        end
        for (int i = 0; i < N; i++) begin
            nb[i] += int'(beat[i]);
            nd[i] += int'(done[i]);
        end
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                rem[i] = 0; rel[i] = 0; waitc[i] = 0; stv[i] = 0;
            end
            err_m = 0;
        end else begin
            if ((|(grant & ~req_e)) || ($countones(grant) > 1)) err_m = 1;
            for (int i = 0; i < N; i++) begin
                if (rel[i]) begin
                    rel[i] = 0;
                end else if (rem[i] == 0) begin
                    if (cmd_valid[i]) rem[i] = int'(cmd_len[i*LW +: LW]) + 1;
                end else if (grant[i]) begin
                    rem[i]--;
                    waitc[i] = 0;
                    stv[i] = 0;
                    if (rem[i] == 0) rel[i] = 1;
                end else begin
                    if (waitc[i] < T) waitc[i]++;
                    stv[i] = (waitc[i] >= T);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; cmd_valid = '0; grant = '0;
        cycle();
        rst = 0;
    endtask

    task automatic issue(input int e, input int len);
        cmd_valid = '0;
        cmd_valid[e] = 1'b1;
        cmd_len[e*LW +: LW] = LW'(len);
        cycle();
        cmd_valid = '0;
    endtask

    initial begin
        @(negedge clk);
        cycle();
        cycle();
        rst = 0;
        chk_en = 1;
        cycle();
        chk("reset_ready", 32'(cmd_ready), 32'hF);

        // single burst, 4 beats on engine 0
        clr_counts();
        issue(0, 3);
        grant = 4'b0001;
        repeat (4) cycle();
        grant = '0;
        repeat (2) cycle();
        chk("burst0_beats", nb[0], 4);
        chk("burst0_done", nd[0], 1);

        // grant interrupted mid-burst on engine 1
        clr_counts();
        issue(1, 2);
        grant = 4'b0010; cycle();
        grant = '0; repeat (3) cycle();
        grant = 4'b0010; repeat (2) cycle();
        grant = '0; repeat (2) cycle();
        chk("burst1_beats", nb[1], 3);
        chk("burst1_done", nd[1], 1);

        // starvation on engine 2
        issue(2, 0);
        repeat (20) cycle();
        #1 chk("starve2_set", 32'(starve[2]), 1);
        grant = 4'b0100; cycle();
        grant = '0;
        #1 chk("starve2_clr", 32'(starve[2]), 0);
        repeat (2) cycle();

        // grant to an idle engine
        grant = 4'b0100; cycle();
        grant = '0;
        #1 chk("err_idle_grant", 32'(err), 1);
        repeat (3) cycle();
        #1 chk("err_sticky", 32'(err), 1);
        do_reset();
        cycle();

        // multi-hot grant to two requesting engines
        cmd_valid = 4'b0011;
        cmd_len = '0;
        cycle();
        cmd_valid = '0;
        grant = 4'b0011; cycle();
        grant = '0;
        #1 chk("err_multi_hot", 32'(err), 1);
        repeat (2) cycle();
        do_reset();

        // all engines back-to-back single-beat bursts under a round-robin arbiter
        clr_counts();
        cmd_valid = 4'hF;
        cmd_len = '0;
        for (int c = 0; c < 40; c++) begin
            grant = '0;
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (ptr + k) % N;
                if (rem[idx] > 0) begin
                    grant[idx] = 1'b1;
                    ptr = (idx + 1) % N;
                    break;
                end
            end
            cycle();
        end
        cmd_valid = '0; grant = '0;
        repeat (3) cycle();
        for (int i = 0; i < N; i++) chk($sformatf("rot_done%0d", i), 32'(nd[i] >= 4), 1);
        chk("rot_no_err", 32'(err), 0);

        // reset in the middle of an 8-beat burst on engine 3
        issue(3, 7);
        grant = 4'b1000; cycle();
        rst = 1; cycle();
        rst = 0; grant = '0;
        #1 chk("rst_mid_req", 32'(req), 0);
        chk("rst_mid_done", 32'(done), 0);
        chk("rst_mid_ready", 32'(cmd_ready), 32'hF);
        cycle();

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            logic [N-1:0] rq;
            int r;
            rq = req_model();
            cmd_valid = N'($urandom);
            cmd_len = (N*LW)'($urandom);
            rst = ($urandom_range(0, 99) < 2);
            r = $urandom_range(0, N-1);
            grant = '0;
            if (rq[r] && ($urandom_range(0, 3) == 0)) grant[r] = 1'b1;
            if ($urandom_range(0, 249) == 0) grant = N'($urandom);
            cycle();
        end
        rst = 0; cmd_valid = '0; grant = '0;
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
